// File: rtl/serial_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : serial_link_arbiter
// Description : Shares one 32-bit serial link among NCLIENTS packet clients;
//               round-robin outbound, in-order inbound routing via a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_link_arbiter #(
  parameter int NCLIENTS = 2,
  parameter int DEPTH    = 4,
  parameter int LEN_BITS = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NCLIENTS-1:0]    client_out_valid,
  output logic [NCLIENTS-1:0]    client_out_ready,
  input  logic [32*NCLIENTS-1:0] client_out_bits,
  output logic [NCLIENTS-1:0]    client_in_valid,
  input  logic [NCLIENTS-1:0]    client_in_ready,
  output logic [32*NCLIENTS-1:0] client_in_bits,
  output logic                   serial_out_valid,
  input  logic                   serial_out_ready,
  output logic [31:0]            serial_out_bits,
  input  logic                   serial_in_valid,
  output logic                   serial_in_ready,
  input  logic [31:0]            serial_in_bits,
  output logic                   busy
);

  localparam int c_IDW = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;
  localparam int c_SW  = c_IDW + 1;
  localparam int c_PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {OIDLE = 2'd0, OHDR = 2'd1, OBODY = 2'd2} ostate_e;
  typedef enum logic [1:0] {IIDLE = 2'd0, IHDR = 2'd1, IBODY = 2'd2} istate_e;

  ostate_e             o_state_q, o_state_d;
  istate_e             i_state_q, i_state_d;
  logic [c_IDW-1:0]    owner_q, owner_d;
  logic [c_IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [c_IDW-1:0]    target_q, target_d;
  logic [LEN_BITS-1:0] rem_q, rem_d;
  logic [LEN_BITS-1:0] rem_in_q, rem_in_d;
  logic [c_IDW-1:0]    fifo_mem_q [DEPTH];
  logic [c_PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [c_PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [c_CW-1:0]     count_q, count_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*NCLIENTS-1:0] req_dbl;
  logic [NCLIENTS-1:0] req_rot;
  logic [c_SW-1:0]     pick_sum;
  logic [c_IDW-1:0]    pick;
  logic                pick_found;
  logic [c_SW-1:0]     owner_inc;
  logic                o_xfer, i_xfer;

  assign fifo_full      = (count_q == c_CW'(DEPTH));
  assign fifo_empty     = (count_q == '0);
  assign busy           = (o_state_q != OIDLE) || !fifo_empty;
  assign client_in_bits = {NCLIENTS{serial_in_bits}};

  // Rotate requests so bit 0 is rr_ptr; lowest set bit is the winner.
  always_comb begin
    req_dbl    = {client_out_valid, client_out_valid};
    req_rot    = NCLIENTS'(req_dbl >> rr_ptr_q);
    pick_sum   = '0;
    pick_found = 1'b0;
    for (int j = NCLIENTS - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        pick_sum   = {1'b0, rr_ptr_q} + c_SW'(j);
        pick_found = 1'b1;
      end
    end
    if (pick_sum >= c_SW'(NCLIENTS)) pick_sum = pick_sum - c_SW'(NCLIENTS);
    pick = pick_sum[c_IDW-1:0];
  end

  always_comb begin
    serial_out_bits = '0;
    for (int i = 0; i < NCLIENTS; i++) begin
      if (owner_q == c_IDW'(i)) serial_out_bits = client_out_bits[32*i +: 32];
    end
  end

  always_comb begin
    o_state_d        = o_state_q;
    owner_d          = owner_q;
    rr_ptr_d         = rr_ptr_q;
    rem_d            = rem_q;
    client_out_ready = '0;
    serial_out_valid = 1'b0;
    fifo_push        = 1'b0;
    owner_inc        = {1'b0, owner_q} + c_SW'(1);
    if (owner_inc >= c_SW'(NCLIENTS)) owner_inc = '0;
    if (o_state_q != OIDLE) begin
      serial_out_valid          = client_out_valid[owner_q];
      client_out_ready[owner_q] = serial_out_ready;
    end
    o_xfer = serial_out_valid && serial_out_ready;
    case (o_state_q)
      OIDLE: begin
        if (pick_found && !fifo_full) begin
          owner_d   = pick;
          o_state_d = OHDR;
        end
      end
      OHDR: begin
        if (o_xfer) begin
          fifo_push = 1'b1;
          rem_d     = serial_out_bits[LEN_BITS-1:0];
          rr_ptr_d  = owner_inc[c_IDW-1:0];
          o_state_d = (serial_out_bits[LEN_BITS-1:0] == '0) ? OIDLE : OBODY;
        end
      end
      OBODY: begin
        if (o_xfer) begin
          rem_d = rem_q - LEN_BITS'(1);
          if (rem_q == LEN_BITS'(1)) o_state_d = OIDLE;
        end
      end
      default: o_state_d = OIDLE;
    endcase
  end

  // Target stays at the FIFO head for the whole response; pop on its last word.
  always_comb begin
    i_state_d       = i_state_q;
    target_d        = target_q;
    rem_in_d        = rem_in_q;
    client_in_valid = '0;
    serial_in_ready = 1'b0;
    fifo_pop        = 1'b0;
    if (i_state_q != IIDLE) begin
      client_in_valid[target_q] = serial_in_valid;
      serial_in_ready           = client_in_ready[target_q];
    end
    i_xfer = serial_in_valid && serial_in_ready;
    case (i_state_q)
      IIDLE: begin
        if (!fifo_empty) begin
          target_d  = fifo_mem_q[rd_ptr_q];
          i_state_d = IHDR;
        end
      end
      IHDR: begin
        if (i_xfer) begin
          rem_in_d = serial_in_bits[LEN_BITS-1:0];
          if (serial_in_bits[LEN_BITS-1:0] == '0) begin
            fifo_pop  = 1'b1;
            i_state_d = IIDLE;
          end else begin
            i_state_d = IBODY;
          end
        end
      end
      IBODY: begin
        if (i_xfer) begin
          rem_in_d = rem_in_q - LEN_BITS'(1);
          if (rem_in_q == LEN_BITS'(1)) begin
            fifo_pop  = 1'b1;
            i_state_d = IIDLE;
          end
        end
      end
      default: i_state_d = IIDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_push) wr_ptr_d = (wr_ptr_q == c_PW'(DEPTH - 1)) ? '0 : wr_ptr_q + c_PW'(1);
    if (fifo_pop)  rd_ptr_d = (rd_ptr_q == c_PW'(DEPTH - 1)) ? '0 : rd_ptr_q + c_PW'(1);
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + c_CW'(1);
      2'b01:   count_d = count_q - c_CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (fifo_push) fifo_mem_q[wr_ptr_q] <= owner_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      o_state_q <= OIDLE;
      i_state_q <= IIDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      target_q  <= '0;
      rem_q     <= '0;
      rem_in_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      o_state_q <= o_state_d;
      i_state_q <= i_state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      target_q  <= target_d;
      rem_q     <= rem_d;
      rem_in_q  <= rem_in_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_link_arbiter
// Description : Directed vector table plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_link_arbiter;

  logic        clock, reset;
  logic [1:0]  cov, co_ready, ci_valid, ci_ready;
  logic [31:0] b0, b1, sob, sib;
  logic [63:0] cib;
  logic        so_valid, so_ready, si_valid, si_ready, busy;

  serial_link_arbiter #(.NCLIENTS(2), .DEPTH(4), .LEN_BITS(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .client_out_valid (cov),
    .client_out_ready (co_ready),
    .client_out_bits  ({b1, b0}),
    .client_in_valid  (ci_valid),
    .client_in_ready  (ci_ready),
    .client_in_bits   (cib),
    .serial_out_valid (so_valid),
    .serial_out_ready (so_ready),
    .serial_out_bits  (sob),
    .serial_in_valid  (si_valid),
    .serial_in_ready  (si_ready),
    .serial_in_bits   (sib),
    .busy             (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  cov;
    logic [31:0] b0;
    logic        sor;
    logic        siv;
    logic [31:0] sib;
    logic [1:0]  cir;
    logic [1:0]  e_cord;
    logic        e_sov;
    logic [31:0] e_sob;
    logic        e_sir;
    logic [1:0]  e_civ;
    logic        e_busy;
  } vec_t;

  vec_t        vt [7];
  int          errors = 0;
  int          checks = 0;
  int          n, m, idx0, idx1, lat;
  logic        x0, x1, hold_seen;
  logic [31:0] lg [16];
  logic [1:0]  own [4];
  logic [31:0] w0 [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cov = '0; b0 = '0; b1 = '0; so_ready = 1'b0;
    si_valid = 1'b0; sib = '0; ci_ready = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Route FIFO must never overflow or underflow.
  always @(posedge clock) begin
    if (!reset) begin
      if (dut.fifo_push && !dut.fifo_pop && dut.count_q == 3'd4) begin
        errors++;
        $display("FAIL fifo_overflow: push with count %0d", dut.count_q);
      end
      if (dut.fifo_pop && dut.count_q == 3'd0) begin
        errors++;
        $display("FAIL fifo_underflow: pop with count %0d", dut.count_q);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // cov, b0, sor, siv, sib, cir | cord, sov, sob, sir, civ, busy
    vt[0] = '{2'b01, 32'h2,  1'b1, 1'b1, 32'h55, 2'b11, 2'b00, 1'b0, 32'h0,  1'b0, 2'b00, 1'b0};
    vt[1] = '{2'b01, 32'h2,  1'b0, 1'b0, 32'h0,  2'b11, 2'b00, 1'b1, 32'h2,  1'b0, 2'b00, 1'b1};
    vt[2] = '{2'b01, 32'h2,  1'b1, 1'b0, 32'h0,  2'b11, 2'b01, 1'b1, 32'h2,  1'b0, 2'b00, 1'b1};
    vt[3] = '{2'b01, 32'hA1, 1'b1, 1'b1, 32'h1,  2'b11, 2'b01, 1'b1, 32'hA1, 1'b0, 2'b00, 1'b1};
    vt[4] = '{2'b01, 32'hA2, 1'b1, 1'b1, 32'h1,  2'b11, 2'b01, 1'b1, 32'hA2, 1'b1, 2'b01, 1'b1};
    vt[5] = '{2'b00, 32'h0,  1'b1, 1'b1, 32'hB1, 2'b11, 2'b00, 1'b0, 32'h0,  1'b1, 2'b01, 1'b1};
    vt[6] = '{2'b00, 32'h0,  1'b1, 1'b0, 32'h0,  2'b11, 2'b00, 1'b0, 32'h0,  1'b0, 2'b00, 1'b0};

    // Single request/response through the vector table.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cov = vt[i].cov; b0 = vt[i].b0; b1 = '0; so_ready = vt[i].sor;
      si_valid = vt[i].siv; sib = vt[i].sib; ci_ready = vt[i].cir;
      @(negedge clock);
      chk($sformatf("r%0d co_ready", i), 64'(co_ready), 64'(vt[i].e_cord));
      chk($sformatf("r%0d so_valid", i), 64'(so_valid), 64'(vt[i].e_sov));
      if (vt[i].e_sov) chk($sformatf("r%0d so_bits", i), 64'(sob), 64'(vt[i].e_sob));
      chk($sformatf("r%0d si_ready", i), 64'(si_ready), 64'(vt[i].e_sir));
      chk($sformatf("r%0d ci_valid", i), 64'(ci_valid), 64'(vt[i].e_civ));
      if (vt[i].e_civ != 2'b00) chk($sformatf("r%0d ci_lanes", i), cib, {vt[i].sib, vt[i].sib});
      chk($sformatf("r%0d busy", i), 64'(busy), 64'(vt[i].e_busy));
      tick();
    end

    // Round-robin with both clients always offering header-only packets.
    do_reset();
    cov = 2'b11; b0 = '0; b1 = '0; so_ready = 1'b1; si_valid = 1'b1; sib = '0; ci_ready = 2'b11;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clock);
      if (so_valid && so_ready) begin
        own[n] = co_ready;
        n++;
      end
      tick();
    end
    chk("rr count", 64'(n), 64'd4);
    chk("rr grant0", 64'(own[0]), 64'(2'b01));
    chk("rr grant1", 64'(own[1]), 64'(2'b10));
    chk("rr grant2", 64'(own[2]), 64'(2'b01));
    chk("rr grant3", 64'(own[3]), 64'(2'b10));

    // No interleave while serial_out_ready toggles.
    do_reset();
    w0[0] = 32'h5;
    for (int k = 1; k < 6; k++) w0[k] = 32'hC000_0000 + 32'(k);
    si_valid = 1'b0; ci_ready = 2'b11;
    idx0 = 0; idx1 = 0; m = 0;
    for (int c = 0; c < 60 && m < 7; c++) begin
      cov[0] = (idx0 < 6);
      b0 = (idx0 < 6) ? w0[idx0] : 32'h0;
      cov[1] = (c >= 3) && (idx1 < 1);
      b1 = 32'h1111_0000;
      so_ready = ((c % 2) == 1);
      @(negedge clock);
      x0 = cov[0] && co_ready[0];
      x1 = cov[1] && co_ready[1];
      if (so_valid && so_ready && m < 16) begin
        lg[m] = sob;
        m++;
      end
      tick();
      if (x0) idx0++;
      if (x1) idx1++;
    end
    chk("nointerleave count", 64'(m), 64'd7);
    for (int k = 0; k < 6; k++) chk($sformatf("nointerleave w%0d", k), 64'(lg[k]), 64'(w0[k]));
    chk("nointerleave client1", 64'(lg[6]), 64'h1111_0000);

    // FIFO full holds a fifth request until one response header is taken.
    do_reset();
    cov = 2'b01; b0 = '0; b1 = '0; so_ready = 1'b1; si_valid = 1'b0; sib = '0; ci_ready = 2'b11;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clock);
      if (so_valid && so_ready) n++;
      tick();
    end
    chk("full sent", 64'(n), 64'd4);
    hold_seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (co_ready != 2'b00 || so_valid) hold_seen = 1'b1;
      tick();
    end
    chk("full held", 64'(hold_seen), 64'd0);
    chk("full count", 64'(dut.count_q), 64'd4);
    si_valid = 1'b1; sib = '0;
    @(negedge clock);
    chk("full resp accept", 64'({si_ready, ci_valid}), 64'(3'b101));
    tick();
    si_valid = 1'b0;
    lat = -1;
    for (int c = 0; c < 6 && lat < 0; c++) begin
      @(negedge clock);
      if (so_valid && so_ready && co_ready[0]) lat = c;
      tick();
    end
    chk("full regrant latency", 64'(lat), 64'd1);

    // Response ordering and inbound backpressure.
    do_reset();
    cov = 2'b10; b0 = '0; b1 = '0; so_ready = 1'b1; si_valid = 1'b0; sib = '0; ci_ready = 2'b01;
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clock);
      if (so_valid && so_ready) begin
        own[n] = co_ready;
        n++;
      end
      tick();
      cov = (n == 0) ? 2'b10 : (n == 1) ? 2'b01 : 2'b00;
    end
    chk("order req count", 64'(n), 64'd2);
    chk("order req first", 64'(own[0]), 64'(2'b10));
    chk("order req second", 64'(own[1]), 64'(2'b01));
    si_valid = 1'b1; sib = '0;
    @(negedge clock);
    chk("order stall a", 64'({si_ready, ci_valid}), 64'(3'b010));
    tick();
    @(negedge clock);
    chk("order stall b", 64'({si_ready, ci_valid}), 64'(3'b010));
    tick();
    ci_ready = 2'b11;
    @(negedge clock);
    chk("order resp1", 64'({si_ready, ci_valid}), 64'(3'b110));
    tick();
    @(negedge clock);
    chk("order gap", 64'({si_ready, ci_valid}), 64'(3'b000));
    tick();
    @(negedge clock);
    chk("order resp0", 64'({si_ready, ci_valid}), 64'(3'b101));
    tick();
    si_valid = 1'b0;
    @(negedge clock);
    chk("order busy", 64'(busy), 64'd0);
    chk("order count", 64'(dut.count_q), 64'd0);
    tick();

    // Reset during the body of an L=3 packet.
    do_reset();
    cov = 2'b01; b0 = 32'h3; b1 = '0; so_ready = 1'b1; si_valid = 1'b0; ci_ready = 2'b11;
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clock);
      if (so_valid && so_ready) n++;
      tick();
      b0 = (n == 0) ? 32'h3 : 32'hE1;
    end
    chk("midrst sent", 64'(n), 64'd2);
    reset = 1'b1;
    @(negedge clock);
    tick();
    @(negedge clock);
    chk("midrst outputs", 64'({co_ready, so_valid, si_ready, ci_valid, busy}), 64'd0);
    chk("midrst count", 64'(dut.count_q), 64'd0);
    chk("midrst rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
    tick();
    @(negedge clock);
    chk("midrst held", 64'({co_ready, so_valid, si_ready, ci_valid, busy}), 64'd0);
    tick();
    reset = 1'b0; cov = 2'b10; b0 = '0; b1 = 32'h1;
    m = 0;
    for (int c = 0; c < 20 && m < 2; c++) begin
      @(negedge clock);
      if (so_valid && so_ready) begin
        lg[m] = sob;
        own[m] = co_ready;
        m++;
      end
      tick();
      b1 = (m == 0) ? 32'h1 : 32'hD1;
      cov = (m < 2) ? 2'b10 : 2'b00;
    end
    chk("postrst count", 64'(m), 64'd2);
    chk("postrst hdr", 64'(lg[0]), 64'h1);
    chk("postrst body", 64'(lg[1]), 64'hD1);
    chk("postrst owner", 64'({own[0], own[1]}), 64'(4'b1010));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_link_arbiter.md
Name: serial_link_arbiter

Overview:
- Shares one 32-bit tethered serial link (host-side serial_out/serial_in channel pair, as driven by the simulation serial endpoint) between NCLIENTS word-serial requesters.
- Outbound: whole packets are arbitrated round-robin and never interleaved.
- Inbound: response packets are steered back to the originating client, in request order, using an internal route FIFO.
- Sits between the per-client serial adapters and the single link endpoint.

Parameters:
- NCLIENTS, 2, number of requesters (2..8).
- DEPTH, 4, route FIFO entries; this is the maximum number of outstanding requests (power of 2).
- LEN_BITS, 8, width of the payload-length field in header word bits [LEN_BITS-1:0].

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- client_out_valid  input  NCLIENTS  per-client outbound word valid.
- client_out_ready  output  NCLIENTS  per-client outbound word ready.
- client_out_bits  input  32*NCLIENTS  outbound words; client i occupies [32i+31:32i].
- client_in_valid  output  NCLIENTS  per-client inbound word valid.
- client_in_ready  input  NCLIENTS  per-client inbound word ready.
- client_in_bits  output  32*NCLIENTS  inbound words; the same serial_in_bits value is replicated to all lanes.
- serial_out_valid  output  1  link outbound valid.
- serial_out_ready  input  1  link outbound ready.
- serial_out_bits  output  32  link outbound word.
- serial_in_valid  input  1  link inbound valid.
- serial_in_ready  output  1  link inbound ready.
- serial_in_bits  input  32  link inbound word.
- busy  output  1  high when the outbound FSM is not in OIDLE or the route FIFO is non-empty.

Behaviour:
- Handshake: a word transfers on a rising edge where valid && ready. All valid/ready outputs are combinational from registered state plus the opposite side's valid/ready. No output waits on its own input.
- Packet format:
  - Word 0 is the header; its payload length L = header[LEN_BITS-1:0].
  - L payload words follow, for L+1 words total. L=0 is a header-only packet.
  - Request and response packets both use this format.
- Outbound FSM, states OIDLE, OHDR, OBODY:
  - OIDLE:
    - All client_out_ready=0 and serial_out_valid=0.
    - If any client_out_valid is set and the route FIFO count < DEPTH, latch owner = first valid client scanning (rr_ptr, rr_ptr+1, ... mod NCLIENTS), then go to OHDR.
    - The selection costs one bubble cycle. No word moves in OIDLE.
  - OHDR / OBODY pass-through:
    - serial_out_valid = client_out_valid[owner]; serial_out_bits = that client's word.
    - client_out_ready[owner] = serial_out_ready; all other client_out_ready are 0.
  - OHDR on transfer:
    - Latch remaining = L.
    - Push owner into the route FIFO.
    - Set rr_ptr = owner+1 mod NCLIENTS.
    - Go to OIDLE if L==0, else OBODY.
  - OBODY on transfer: decrement remaining. When a transfer occurs with remaining==1, go to OIDLE.
  - Other valid clients stall for the whole packet; there is no preemption.
- Full FIFO: no grant in OIDLE. At most one push can occur per grant, so the check at grant time is sufficient.
- Inbound FSM, states IIDLE, IHDR, IBODY:
  - IIDLE:
    - serial_in_ready=0 and all client_in_valid=0.
    - If the FIFO is non-empty, latch target = FIFO head and go to IHDR.
    - Inbound words arriving while the FIFO is empty are stalled and never dropped.
  - IHDR / IBODY pass-through: client_in_valid[target] = serial_in_valid and serial_in_ready = client_in_ready[target]. Other client_in_valid are 0.
  - IHDR on transfer: latch remaining_in = L. If L==0, pop the FIFO and go to IIDLE; else go to IBODY.
  - IBODY on transfer: decrement. A transfer with remaining_in==1 pops the FIFO and goes to IIDLE.
- Route FIFO:
  - Stores a clog2(NCLIENTS)-bit client id.
  - A push and a pop in the same cycle are legal, and count is unchanged.
  - Pointers wrap modulo DEPTH.
  - Push when full and pop when empty cannot occur by construction. The verification engineer must assert both.
- Outbound and inbound FSMs run concurrently. A response may stream in while the next request streams out.
- Reset (also mid-packet):
  - Both FSMs go to idle, the FIFO empties (count=0), rr_ptr=0, and remaining counters are 0.
  - All valid/ready outputs are 0 and busy=0 in the cycle after reset asserts, and they stay 0 while reset is held.
  - A partially sent packet is abandoned. Recovery is the clients' responsibility.

Test Plan:
- Single request: client 0 sends header 0x00000002 plus two words, link always ready. The three words appear on serial_out on consecutive cycles after one bubble, and busy=1. A response with header 0x00000001 plus one word is delivered only on client_in lane 0, after which the FIFO is empty and busy=0.
- Round-robin fairness: both clients continuously offer L=0 packets. Grants alternate 0,1,0,1, and client 0 wins first after reset.
- No interleave: client 1 becomes valid during client 0's L=5 body with serial_out_ready toggling every cycle. All six client-0 words are contiguous on serial_out before any client-1 word.
- FIFO full, DEPTH=4: four L=0 requests are sent with no responses. A fifth pending request is held with client_out_ready=0 until one response header (L=0) is consumed, then it is granted.
- Ordering and backpressure: requests are sent by client 1 then client 0. Responses route to 1 then 0. Holding client_in_ready[1]=0 keeps serial_in_ready=0 and nothing reaches client 0.
- Reset mid-packet: reset is asserted during the OBODY of an L=3 packet. The next cycle shows all outputs 0, count 0 and rr_ptr=0, and a fresh client-1 packet afterwards transfers normally.
